adc_acq_seq: RTL



---
 rtl/adc_acq_pkg.sv | 25 ++
 rtl/adc_acq_rate_meter.sv | 46 ++++
 rtl/adc_acq_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/adc_acq_pkg.sv
// Shared types and helpers for the ADC acquisition sequencer.
package adc_acq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        COLLECT   = 2'd2,
        ABORT     = 2'd3
    } state_e;

    localparam int unsigned RATE_W = 16;

    // Negative raw words clamp to zero; otherwise keep the OUT_W bits just below the sign.
    function automatic logic [31:0] sample_slice(input logic [31:0] raw,
                                                 input int unsigned data_w,
                                                 input int unsigned out_w);
        logic [31:0] mask;
        mask = (32'd1 << out_w) - 32'd1;
        if (((raw >> (data_w - 1)) & 32'd1) != 32'd0) begin
            return '0;
        end
        return (raw >> (data_w - 1 - out_w)) & mask;
    endfunction

endpackage

// File: rtl/adc_acq_rate_meter.sv
// Counts end-of-conversion pulses over a fixed gate window and publishes the total at each wrap.
module adc_acq_rate_meter
    import adc_acq_pkg::*;
#(
    parameter int unsigned RATE_WINDOW = 27000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              eoc_i,
    output logic [RATE_W-1:0] rate_o
);

    localparam int unsigned WIN_W = (RATE_WINDOW > 1) ? $clog2(RATE_WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(RATE_WINDOW - 1);

    logic [WIN_W-1:0]  win_q, win_d;
    logic [RATE_W-1:0] evt_q, evt_d, rate_q, rate_d, evt_inc;

    always_comb begin
        evt_inc = (eoc_i && (evt_q != '1)) ? evt_q + 1'b1 : evt_q;
        win_d   = win_q + 1'b1;
        evt_d   = evt_inc;
        rate_d  = rate_q;
        // A pulse landing on the wrap cycle belongs to the window that is closing.
        if (win_q == WIN_LAST) begin
            win_d  = '0;
            evt_d  = '0;
            rate_d = evt_inc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_q  <= '0;
            evt_q  <= '0;
            rate_q <= '0;
        end else begin
            win_q  <= win_d;
            evt_q  <= evt_d;
            rate_q <= rate_d;
        end
    end

    assign rate_o = rate_q;

endmodule

// File: rtl/adc_acq_seq.sv
// N-channel ADC acquisition sequencer with timeout abort, overrun flag and atomic commit.
// Define ADC_ACQ_RATE_EN to build the measured conversion-rate readout on rate_o.
module adc_acq_seq
    import adc_acq_pkg::*;
#(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned OUT_W          = 12,
    parameter int unsigned TIMEOUT_CYCLES = 270000,
    parameter int unsigned RATE_WINDOW    = 27000000
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     clear_i,
    output logic [NUM_CH-1:0]        adc_enable_o,
    input  logic [NUM_CH-1:0]        adc_ready_i,
    input  logic [NUM_CH*DATA_W-1:0] adc_data_i,
    output logic [NUM_CH*OUT_W-1:0]  sample_o,
    output logic                     eoc_o,
    output logic                     busy_o,
    output logic                     overrun_o,
    output logic                     timeout_o,
    output logic [RATE_W-1:0]        rate_o
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);

    state_e                  state_q, state_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [NUM_CH-1:0]       en_q, en_d, done_q, done_d;
    logic [NUM_CH*OUT_W-1:0] shadow_q, shadow_d, sample_q, sample_d;
    logic                    eoc_q, eoc_d, ovr_q, ovr_d, tmo_q, tmo_d;
    logic                    tmo_hit;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        en_d     = en_q;
        done_d   = done_q;
        shadow_d = shadow_q;
        sample_d = sample_q;
        eoc_d    = 1'b0;
        ovr_d    = start_i && (state_q != IDLE);
        tmo_d    = tmo_q && !clear_i;
        tmo_hit  = (timer_q == TMR_LAST);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    en_d    = '1;
                    done_d  = '0;
                    timer_d = '0;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (timer_q != TMR_MAX) timer_d = timer_q + 1'b1;
                if (tmo_hit) begin
                    en_d    = '0;
                    tmo_d   = 1'b1;
                    state_d = ABORT;
                end else if (adc_ready_i == '0) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (timer_q != TMR_MAX) timer_d = timer_q + 1'b1;
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    if (adc_ready_i[k] && !done_q[k]) begin
                        shadow_d[k*OUT_W +: OUT_W] =
                            OUT_W'(sample_slice(32'(adc_data_i[k*DATA_W +: DATA_W]), DATA_W, OUT_W));
                        en_d[k]   = 1'b0;
                        done_d[k] = 1'b1;
                    end
                end
                // Timeout outranks completion so a late final capture cannot commit.
                if (tmo_hit) begin
                    en_d    = '0;
                    tmo_d   = 1'b1;
                    state_d = ABORT;
                end else if (&done_q) begin
                    sample_d = shadow_q;
                    eoc_d    = 1'b1;
                    state_d  = IDLE;
                end
            end
            ABORT: begin
                shadow_d = '0;
                done_d   = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            en_q     <= '0;
            done_q   <= '0;
            shadow_q <= '0;
            sample_q <= '0;
            eoc_q    <= 1'b0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            en_q     <= en_d;
            done_q   <= done_d;
            shadow_q <= shadow_d;
            sample_q <= sample_d;
            eoc_q    <= eoc_d;
            ovr_q    <= ovr_d;
            tmo_q    <= tmo_d;
        end
    end

    assign adc_enable_o = en_q;
    assign sample_o     = sample_q;
    assign eoc_o        = eoc_q;
    assign busy_o       = (state_q != IDLE);
    assign overrun_o    = ovr_q;
    assign timeout_o    = tmo_q;

`ifdef ADC_ACQ_RATE_EN
    adc_acq_rate_meter #(
        .RATE_WINDOW(RATE_WINDOW)
    ) u_rate (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .eoc_i (eoc_q),
        .rate_o(rate_o)
    );
`else
    assign rate_o = '0;
`endif

endmodule
